ula_arbitro: RTL and testbench
==============================

ULA_ARBITRO -- requirements
Module: ula_arbitro

Interface
REQ-001 Parameter BITS_PALAVRA, default 16, SHALL set the operand and result width.
REQ-002 Parameter BITS_CONTROLE, default 5, SHALL set the ALU control-code width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  2  SHALL carry per-requester operation-request valids (bit i = requester i).
REQ-006 req_ready  output  2  SHALL carry per-requester request-accept strobes.
REQ-007 req_operandoA  input  2*BITS_PALAVRA  SHALL carry packed operand A; requester i at slice i.
REQ-008 req_operandoB  input  2*BITS_PALAVRA  SHALL carry packed operand B; requester i at slice i.
REQ-009 req_controle  input  2*BITS_CONTROLE  SHALL carry packed ALU control codes; requester i at slice i.
REQ-010 resp_valid  output  2  SHALL carry per-requester response valids, at most one bit high.
REQ-011 resp_ready  input  2  SHALL carry per-requester response accepts.
REQ-012 resp_resultado  output  BITS_PALAVRA  SHALL carry the captured result, qualified by resp_valid.
REQ-013 resp_flags  output  4  SHALL carry the captured flags {Z,C,S,O}, qualified by resp_valid.
REQ-014 ula_operandoA, ula_operandoB  output  BITS_PALAVRA each  SHALL drive the shared ALU operands.
REQ-015 ula_controle  output  BITS_CONTROLE  SHALL drive the shared ALU control code.
REQ-016 ula_resultado  input  BITS_PALAVRA, ula_flags  input  4 {Z,C,S,O}  SHALL return the combinational ALU outputs.

Function
REQ-017 FSM SHALL have exactly three states: OCIOSO, EXECUTA, RESPONDE.
REQ-018 OCIOSO: when any req_valid is high, the arbiter SHALL select grant g, assert req_ready[g] combinationally in the same cycle, and at that edge register slice g into the ula_* outputs and go to EXECUTA.
REQ-019 req_ready SHALL be 0 in EXECUTA and RESPONDE; requests are not accepted outside OCIOSO, and an unselected requester SHALL keep waiting without loss.
REQ-020 EXECUTA: lasts exactly one cycle; at its closing edge ula_resultado and ula_flags SHALL be captured into resp_resultado/resp_flags; next state RESPONDE.
REQ-021 RESPONDE: resp_valid[g] SHALL be held high with stable data until resp_ready[g] is sampled high; then next state OCIOSO; resp_ready of the other requester SHALL be ignored.
REQ-022 Latency: response valid SHALL appear 2 cycles after the accept edge; minimum issue interval 3 cycles.
REQ-023 ula_controle SHALL be forwarded unchanged (no decoding, undefined codes passed through).
REQ-024 ula_* outputs SHALL hold their last values outside EXECUTA.
REQ-025 A 16-bit counter contador_ops (internal, visible to the bench) SHALL increment on each completed response handshake and wrap from 0xFFFF to 0.

Reset
REQ-026 Asserting reset_n low SHALL immediately force OCIOSO, req_ready=0, resp_valid=0, resp_resultado=0, resp_flags=0, ula_*=0, contador_ops=0, and round-robin pointer ultimo=1.
REQ-027 Reset during EXECUTA or RESPONDE SHALL discard the in-flight operation; no response is ever issued for it.

Configuration
REQ-028 With ULA_ARBITRO_ROUND_ROBIN_EN defined: when both req_valid bits are high, grant SHALL go to the requester not equal to ultimo, and ultimo SHALL update to g on each grant.
REQ-029 Without ULA_ARBITRO_ROUND_ROBIN_EN: fixed priority, requester 0 SHALL always win when both request; ultimo is not implemented.

Verification
REQ-030 Single op: req_valid=01, A=0x0003, B=0x0004, ctrl=00000, ALU model returns 0x0007/flags 0000 -> req_ready=01 at accept, resp_valid=01 two cycles later, resp_resultado=0x0007.
REQ-031 Backpressure: hold resp_ready=00 for 5 cycles after resp_valid -> resp_valid, resp_resultado, resp_flags stable; req_ready stays 00 despite req_valid=10.
REQ-032 Contention (RR build): req_valid=11 held for 4 operations -> grant order 0,1,0,1; (fixed build) -> 0,0,0,0.
REQ-033 Reset mid-op: reset_n low during EXECUTA -> all outputs 0 asynchronously, no resp_valid after release, next request from requester 0 wins.
REQ-034 Wrap: preload 0xFFFF completed responses then one more -> contador_ops=0x0000.

Source files
------------

// File: rtl/ula_arbitro.sv
// Two-requester arbiter sharing one combinational ALU; one operation in flight at a time.
// Define ULA_ARBITRO_ROUND_ROBIN_EN for round-robin grant on contention (default: requester 0 wins).
module ula_arbitro #(
  parameter int unsigned BITS_PALAVRA  = 16,
  parameter int unsigned BITS_CONTROLE = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*BITS_PALAVRA-1:0]  req_operandoA,
  input  logic [2*BITS_PALAVRA-1:0]  req_operandoB,
  input  logic [2*BITS_CONTROLE-1:0] req_controle,
  output logic [1:0]                 resp_valid,
  input  logic [1:0]                 resp_ready,
  output logic [BITS_PALAVRA-1:0]    resp_resultado,
  output logic [3:0]                 resp_flags,
  output logic [BITS_PALAVRA-1:0]    ula_operandoA,
  output logic [BITS_PALAVRA-1:0]    ula_operandoB,
  output logic [BITS_CONTROLE-1:0]   ula_controle,
  input  logic [BITS_PALAVRA-1:0]    ula_resultado,
  input  logic [3:0]                 ula_flags
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;

  estado_t estado_q, estado_d;
  logic    grant_d, grant_q;
  logic    aceita, handshake;
  logic [15:0] contador_ops;

`ifdef ULA_ARBITRO_ROUND_ROBIN_EN
  logic ultimo_q;
`endif

  // Grant index; only meaningful while a request is pending in OCIOSO.
  always_comb begin
    grant_d = ~req_valid[0];
`ifdef ULA_ARBITRO_ROUND_ROBIN_EN
    if (req_valid == 2'b11) begin
      grant_d = ~ultimo_q;
    end
`endif
  end

  assign aceita    = (estado_q == OCIOSO) && (|req_valid);
  assign handshake = (estado_q == RESPONDE) && resp_ready[grant_q];

  // Gated by reset_n so the accept strobe drops the instant reset asserts.
  always_comb begin
    req_ready = 2'b00;
    if (aceita && reset_n) begin
      req_ready = grant_d ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    resp_valid = 2'b00;
    if (estado_q == RESPONDE) begin
      resp_valid = grant_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:   if (aceita) estado_d = EXECUTA;
      EXECUTA:  estado_d = RESPONDE;
      RESPONDE: if (handshake) estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q       <= OCIOSO;
      grant_q        <= 1'b0;
      ula_operandoA  <= '0;
      ula_operandoB  <= '0;
      ula_controle   <= '0;
      resp_resultado <= '0;
      resp_flags     <= '0;
      contador_ops   <= 16'd0;
    end else begin
      estado_q <= estado_d;
      if (aceita) begin
        grant_q       <= grant_d;
        ula_operandoA <= grant_d ? req_operandoA[2*BITS_PALAVRA-1:BITS_PALAVRA]
                                 : req_operandoA[BITS_PALAVRA-1:0];
        ula_operandoB <= grant_d ? req_operandoB[2*BITS_PALAVRA-1:BITS_PALAVRA]
                                 : req_operandoB[BITS_PALAVRA-1:0];
        ula_controle  <= grant_d ? req_controle[2*BITS_CONTROLE-1:BITS_CONTROLE]
                                 : req_controle[BITS_CONTROLE-1:0];
      end
      if (estado_q == EXECUTA) begin
        resp_resultado <= ula_resultado;
        resp_flags     <= ula_flags;
      end
      if (handshake) begin
        contador_ops <= contador_ops + 16'd1;
      end
    end
  end

`ifdef ULA_ARBITRO_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ultimo_q <= 1'b1;
    end else if (aceita) begin
      ultimo_q <= grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_ula_arbitro.sv
// Self-checking bench for ula_arbitro: random requests checked against a transaction-level model.
module tb_ula_arbitro;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_operandoA, req_operandoB;
  logic [9:0]  req_controle;
  logic [15:0] resp_resultado, ula_operandoA, ula_operandoB, ula_resultado;
  logic [3:0]  resp_flags, ula_flags;
  logic [4:0]  ula_controle;

  int n_tests = 0;
  int n_fail  = 0;
  int ult_m   = 1;
  int cnt_m   = 0;

  always #5 clock = ~clock;

  ula_arbitro #(.BITS_PALAVRA(16), .BITS_CONTROLE(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operandoA(req_operandoA), .req_operandoB(req_operandoB), .req_controle(req_controle),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_resultado(resp_resultado), .resp_flags(resp_flags),
    .ula_operandoA(ula_operandoA), .ula_operandoB(ula_operandoB), .ula_controle(ula_controle),
    .ula_resultado(ula_resultado), .ula_flags(ula_flags)
  );

  // Reference ALU: result and flags {Z,C,S,O}; unknown codes fold the code into the result.
  function automatic logic [19:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [4:0] c);
    logic [16:0] s;
    logic [15:0] r;
    logic        cy, ov;
    cy = 1'b0;
    ov = 1'b0;
    s  = '0;
    case (c)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0]; cy = s[16];
        ov = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'd1: begin
        s = {1'b0, a} - {1'b0, b}; r = s[15:0]; cy = s[16];
        ov = (a[15] != b[15]) && (r[15] != a[15]);
      end
      default: r = (a & b) ^ {b[10:0], c};
    endcase
    return {r, (r == 16'd0), cy, r[15], ov};
  endfunction

  assign {ula_resultado, ula_flags} = alu(ula_operandoA, ula_operandoB, ula_controle);

  function automatic int exp_grant(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef ULA_ARBITRO_ROUND_ROBIN_EN
      return (ult_m == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return v[0] ? 0 : 1;
  endfunction

  // Full transaction; called at posedge+1. Returns observed grant, response data and latency.
  task automatic issue(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [9:0] c, input int stall, output int g,
                       output logic [15:0] res, output logic [3:0] fl, output int lat);
    req_valid = v; req_operandoA = a; req_operandoB = b; req_controle = c;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (req_ready !== 2'b00) break;
      @(posedge clock); #2;
    end
    g = (req_ready === 2'b01) ? 0 : (req_ready === 2'b10) ? 1 : -1;
    res = '0; fl = '0; lat = 99;
    if (g < 0) begin
      req_valid = 2'b00;
      return;
    end
    @(posedge clock); #1;
    req_valid = 2'b00;
    for (int k = 1; k < 8; k++) begin
      if (resp_valid !== 2'b00) begin
        lat = k;
        break;
      end
      @(posedge clock); #1;
    end
    if (lat == 99) return;
    res = resp_resultado;
    fl  = resp_flags;
    repeat (stall) begin
      @(posedge clock); #1;
    end
    resp_ready = (g == 0) ? 2'b01 : 2'b10;
    @(posedge clock); #1;
    resp_ready = 2'b00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #4;
    reset_n = 1'b1;
    ult_m = 1;
    cnt_m = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
      n_fail++; $display("FAIL reset_handshake: ready=%b valid=%b required 00/00", req_ready,
                         resp_valid);
    end
    n_tests++;
    if (resp_resultado !== 16'd0 || resp_flags !== 4'd0) begin
      n_fail++; $display("FAIL reset_resp: res=%h fl=%h required 0/0", resp_resultado,
                         resp_flags);
    end
    n_tests++;
    if ({ula_operandoA, ula_operandoB, ula_controle} !== 37'd0) begin
      n_fail++; $display("FAIL reset_ula: a=%h b=%h c=%h required 0", ula_operandoA,
                         ula_operandoB, ula_controle);
    end
    n_tests++;
    if (dut.contador_ops !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %h required 0", dut.contador_ops);
    end
  endtask

  task automatic test_single_op();
    req_valid = 2'b01; req_operandoA = {16'h1111, 16'h0003};
    req_operandoB = {16'h2222, 16'h0004}; req_controle = {5'd1, 5'd0};
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_ready: got %b required 01", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 2'b00;
    ult_m = 0;
    n_tests++;
    if (ula_operandoA !== 16'h0003 || ula_operandoB !== 16'h0004 || ula_controle !== 5'd0 ||
        resp_valid !== 2'b00) begin
      n_fail++; $display("FAIL single_exec: a=%h b=%h c=%h valid=%b required 3/4/0/00",
                         ula_operandoA, ula_operandoB, ula_controle, resp_valid);
    end
    @(posedge clock); #1;
    n_tests++;
    if (resp_valid !== 2'b01 || resp_resultado !== 16'h0007 || resp_flags !== 4'h0) begin
      n_fail++; $display("FAIL single_resp: valid=%b res=%h fl=%h required 01/0007/0",
                         resp_valid, resp_resultado, resp_flags);
    end
    resp_ready = 2'b01;
    @(posedge clock); #1;
    resp_ready = 2'b00;
    cnt_m++;
    n_tests++;
    if (resp_valid !== 2'b00 || dut.contador_ops !== 16'(cnt_m)) begin
      n_fail++; $display("FAIL single_done: valid=%b cnt=%0d required 00/%0d", resp_valid,
                         dut.contador_ops, cnt_m);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] r0;
    logic [3:0]  f0;
    int g, lat;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [19:0] e;
    req_valid = 2'b01; req_operandoA = {16'h0, 16'h8000}; req_operandoB = {16'h0, 16'h8000};
    req_controle = 10'd0;
    @(posedge clock); #1;
    ult_m = 0;
    req_valid = 2'b00;
    @(posedge clock); #1;
    r0 = resp_resultado; f0 = resp_flags;
    n_tests++;
    if (resp_valid !== 2'b01 || {r0, f0} !== alu(16'h8000, 16'h8000, 5'd0)) begin
      n_fail++; $display("FAIL bp_first: valid=%b data=%h required 01/%h", resp_valid,
                         {r0, f0}, alu(16'h8000, 16'h8000, 5'd0));
    end
    req_valid = 2'b10; req_operandoA = {16'h1234, 16'h0}; req_operandoB = {16'h0F0F, 16'h0};
    req_controle = {5'd1, 5'd0};
    resp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (resp_valid !== 2'b01 || resp_resultado !== r0 || resp_flags !== f0 ||
          req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b res=%h fl=%h ready=%b required 01/%h/%h/00",
                           i, resp_valid, resp_resultado, resp_flags, req_ready, r0, f0);
      end
      @(posedge clock); #1;
    end
    resp_ready = 2'b01;
    @(posedge clock); #1;
    resp_ready = 2'b00;
    cnt_m++;
    issue(2'b10, {16'h1234, 16'h0}, {16'h0F0F, 16'h0}, {5'd1, 5'd0}, 0, g, res, fl, lat);
    e = alu(16'h1234, 16'h0F0F, 5'd1);
    n_tests++;
    if (g != 1 || {res, fl} !== e) begin
      n_fail++; $display("FAIL bp_waiter: grant=%0d data=%h required 1/%h", g, {res, fl}, e);
    end
    ult_m = 1;
    cnt_m++;
  endtask

  task automatic test_reset_mid_op();
    int g, lat;
    logic [15:0] res;
    logic [3:0]  fl;
    req_valid = 2'b01; req_operandoA = {16'h0, 16'h00AA}; req_operandoB = {16'h0, 16'h0055};
    req_controle = 10'd0;
    @(posedge clock); #1;
    req_valid = 2'b11;
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_resultado !== 16'd0 ||
        resp_flags !== 4'd0 || {ula_operandoA, ula_operandoB, ula_controle} !== 37'd0 ||
        dut.contador_ops !== 16'd0) begin
      n_fail++; $display("FAIL midreset_clear: ready=%b valid=%b res=%h ula_a=%h required all 0",
                         req_ready, resp_valid, resp_resultado, ula_operandoA);
    end
    req_valid = 2'b00;
    @(posedge clock); #3;
    reset_n = 1'b1;
    ult_m = 1;
    cnt_m = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      n_tests++;
      if (resp_valid !== 2'b00) begin
        n_fail++; $display("FAIL midreset_noresp%0d: valid=%b required 00", i, resp_valid);
      end
    end
    issue(2'b11, {16'h3, 16'h1}, {16'h4, 16'h2}, 10'd0, 0, g, res, fl, lat);
    n_tests++;
    if (g != 0 || res !== 16'h0003) begin
      n_fail++; $display("FAIL midreset_next: grant=%0d res=%h required 0/0003", g, res);
    end
    ult_m = 0;
    cnt_m++;
  endtask

  task automatic test_contention();
    int g, lat, eg;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [31:0] a, b;
    logic [9:0]  c;
    logic [19:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; c = 10'($urandom);
      eg = exp_grant(2'b11);
      e = (eg == 0) ? alu(a[15:0], b[15:0], c[4:0]) : alu(a[31:16], b[31:16], c[9:5]);
      issue(2'b11, a, b, c, 0, g, res, fl, lat);
      n_tests++;
      if (g != eg || {res, fl} !== e || lat != 2) begin
        n_fail++; $display("FAIL contention%0d: grant=%0d data=%h lat=%0d required %0d/%h/2",
                           i, g, {res, fl}, lat, eg, e);
      end
      ult_m = eg;
      cnt_m++;
    end
  endtask

  task automatic test_random();
    int g, lat, eg;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [31:0] a, b;
    logic [9:0]  c;
    logic [1:0]  v;
    logic [19:0] e;
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      a = $urandom; b = $urandom; c = 10'($urandom);
      if (i % 5 == 0) b = a;
      eg = exp_grant(v);
      e = (eg == 0) ? alu(a[15:0], b[15:0], c[4:0]) : alu(a[31:16], b[31:16], c[9:5]);
      issue(v, a, b, c, $urandom_range(0, 3), g, res, fl, lat);
      ult_m = eg;
      cnt_m++;
      n_tests++;
      if (g != eg || {res, fl} !== e || lat != 2 || dut.contador_ops !== 16'(cnt_m)) begin
        n_fail++; $display("FAIL random%0d: v=%b grant=%0d data=%h lat=%0d cnt=%0d required %0d/%h/2/%0d",
                           i, v, g, {res, fl}, lat, dut.contador_ops, eg, e, cnt_m);
      end
    end
  endtask

  task automatic test_wrap();
    int g, lat;
    logic [15:0] res;
    logic [3:0]  fl;
    force dut.contador_ops = 16'hFFFF;
    @(posedge clock); #1;
    release dut.contador_ops;
    #1;
    n_tests++;
    if (dut.contador_ops !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_preload: got %h required FFFF", dut.contador_ops);
    end
    issue(2'b01, 32'h5, 32'h6, 10'd0, 1, g, res, fl, lat);
    n_tests++;
    if (dut.contador_ops !== 16'h0000 || res !== 16'h000B) begin
      n_fail++; $display("FAIL wrap: cnt=%h res=%h required 0000/000B", dut.contador_ops, res);
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    req_operandoA = '0; req_operandoB = '0; req_controle = '0;
    #3;
    test_reset();
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_single_op();
    test_backpressure();
    test_reset_mid_op();
    test_contention();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
